// File: rtl/pp_multi_check_if.sv
// Handshake bundle for NCH rdy/ack channels with BW-bit data per channel.
// The checker only observes the bundle through the mon modport.
interface pp_multi_check_if #(
  parameter int NCH = 4,
  parameter int BW  = 8
);
  logic [NCH-1:0]    rdy;
  logic [NCH-1:0]    ack;
  logic [NCH*BW-1:0] dat;

  modport master (output rdy, output dat, input ack);
  modport slave  (input rdy, input dat, output ack);
  modport mon    (input rdy, input ack, input dat);
endinterface

// File: rtl/pp_multi_check.sv
// Passive multi-channel rdy/ack protocol checker with sticky error flags and saturating stats.
// Optional first-error capture enabled by defining PP_MULTI_CHECK_FIRST_ERR_EN.
module pp_multi_check #(
  parameter int NCH       = 4,
  parameter int BW        = 8,
  parameter int CNT_W     = 16,
  parameter int STALL_MAX = 255,
  localparam int SEL_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  pp_multi_check_if.mon    bus,
  input  logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   err_hold,
  output logic [NCH-1:0]   err_ack,
  output logic [NCH-1:0]   err_tmo,
  output logic             any_err,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] max_stall
`ifdef PP_MULTI_CHECK_FIRST_ERR_EN
  ,
  output logic             first_err_vld,
  output logic [SEL_W-1:0] first_err_ch,
  output logic [1:0]       first_err_type,
  output logic [CNT_W-1:0] first_err_time
`endif
);

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_PRE  = CNT_W'(STALL_MAX - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : (v + CNT_ONE);
  endfunction

  state_t           state_r     [NCH];
  state_t           state_nxt_s [NCH];
  logic [BW-1:0]    held_r      [NCH];
  logic [CNT_W-1:0] xfer_r      [NCH];
  logic [CNT_W-1:0] stall_r     [NCH];
  logic [CNT_W-1:0] cur_r       [NCH];
  logic [CNT_W-1:0] max_r       [NCH];
  logic [NCH-1:0]   err_hold_r, err_ack_r, err_tmo_r;
  logic [NCH-1:0]   latch_s, hold_set_s, ack_set_s, tmo_set_s, stall_s, xfer_s;

  // Per-channel next state and violation/event decode
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_nxt_s[i] = state_r[i];
      latch_s[i]     = 1'b0;
      hold_set_s[i]  = 1'b0;
      stall_s[i]     = bus.rdy[i] & ~bus.ack[i];
      xfer_s[i]      = bus.rdy[i] & bus.ack[i];
      ack_set_s[i]   = bus.ack[i] & ~bus.rdy[i];
      // cur_r passes STALL_MAX-1 exactly once per stall since it saturates above STALL_MAX
      tmo_set_s[i]   = stall_s[i] & (cur_r[i] == TMO_PRE);
      case (state_r[i])
        ST_IDLE: begin
          if (stall_s[i]) begin
            state_nxt_s[i] = ST_HOLD;
            latch_s[i]     = 1'b1;
          end else begin
            state_nxt_s[i] = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!bus.rdy[i] || (bus.dat[i*BW +: BW] != held_r[i])) begin
            hold_set_s[i]  = 1'b1;
            state_nxt_s[i] = ST_IDLE;
          end else if (bus.ack[i]) begin
            state_nxt_s[i] = ST_IDLE;
          end else begin
            state_nxt_s[i] = ST_HOLD;
          end
        end
        default: state_nxt_s[i] = ST_IDLE;
      endcase
    end
  end

  // Channel state, held data, statistics and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_r[i] <= ST_IDLE;
        held_r[i]  <= {BW{1'b0}};
        xfer_r[i]  <= {CNT_W{1'b0}};
        stall_r[i] <= {CNT_W{1'b0}};
        cur_r[i]   <= {CNT_W{1'b0}};
        max_r[i]   <= {CNT_W{1'b0}};
      end
      err_hold_r <= {NCH{1'b0}};
      err_ack_r  <= {NCH{1'b0}};
      err_tmo_r  <= {NCH{1'b0}};
    end else if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        state_r[i] <= ST_IDLE;
        held_r[i]  <= {BW{1'b0}};
        xfer_r[i]  <= {CNT_W{1'b0}};
        stall_r[i] <= {CNT_W{1'b0}};
        cur_r[i]   <= {CNT_W{1'b0}};
        max_r[i]   <= {CNT_W{1'b0}};
      end
      err_hold_r <= {NCH{1'b0}};
      err_ack_r  <= {NCH{1'b0}};
      err_tmo_r  <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_r[i] <= state_nxt_s[i];
        if (latch_s[i]) held_r[i] <= bus.dat[i*BW +: BW];
        if (xfer_s[i]) xfer_r[i] <= sat_inc(xfer_r[i]);
        if (stall_s[i]) begin
          stall_r[i] <= sat_inc(stall_r[i]);
          cur_r[i]   <= sat_inc(cur_r[i]);
        end else begin
          // a stall is folded into the maximum only once it has ended
          if (cur_r[i] > max_r[i]) max_r[i] <= cur_r[i];
          cur_r[i] <= {CNT_W{1'b0}};
        end
      end
      err_hold_r <= err_hold_r | hold_set_s;
      err_ack_r  <= err_ack_r  | ack_set_s;
      err_tmo_r  <= err_tmo_r  | tmo_set_s;
    end
  end

  // Statistics read mux; out-of-range select reads zero
  always_comb begin
    if (int'(sel) < NCH) begin
      xfer_cnt  = xfer_r[sel];
      stall_cnt = stall_r[sel];
      max_stall = max_r[sel];
    end else begin
      xfer_cnt  = {CNT_W{1'b0}};
      stall_cnt = {CNT_W{1'b0}};
      max_stall = {CNT_W{1'b0}};
    end
  end

  assign err_hold = err_hold_r;
  assign err_ack  = err_ack_r;
  assign err_tmo  = err_tmo_r;
  assign any_err  = |{err_hold_r, err_ack_r, err_tmo_r};

`ifdef PP_MULTI_CHECK_FIRST_ERR_EN
  logic [CNT_W-1:0] cyc_r;
  logic             fe_vld_r;
  logic [SEL_W-1:0] fe_ch_r;
  logic [1:0]       fe_type_r;
  logic [CNT_W-1:0] fe_time_r;
  logic             fe_hit_s;
  logic [SEL_W-1:0] fe_ch_s;
  logic [1:0]       fe_type_s;

  // Highest-priority new violation this cycle: descending scan lets the lowest channel win
  always_comb begin
    fe_hit_s  = 1'b0;
    fe_ch_s   = {SEL_W{1'b0}};
    fe_type_s = 2'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hold_set_s[i] | ack_set_s[i] | tmo_set_s[i]) begin
        fe_hit_s  = 1'b1;
        fe_ch_s   = SEL_W'(i);
        fe_type_s = hold_set_s[i] ? 2'd1 : (ack_set_s[i] ? 2'd2 : 2'd3);
      end else begin
        fe_hit_s  = fe_hit_s;
      end
    end
  end

  // Cycle counter and one-shot first-error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_r     <= {CNT_W{1'b0}};
      fe_vld_r  <= 1'b0;
      fe_ch_r   <= {SEL_W{1'b0}};
      fe_type_r <= 2'd0;
      fe_time_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cyc_r     <= {CNT_W{1'b0}};
      fe_vld_r  <= 1'b0;
      fe_ch_r   <= {SEL_W{1'b0}};
      fe_type_r <= 2'd0;
      fe_time_r <= {CNT_W{1'b0}};
    end else begin
      cyc_r <= sat_inc(cyc_r);
      if (!fe_vld_r && fe_hit_s) begin
        fe_vld_r  <= 1'b1;
        fe_ch_r   <= fe_ch_s;
        fe_type_r <= fe_type_s;
        fe_time_r <= cyc_r;
      end
    end
  end

  assign first_err_vld  = fe_vld_r;
  assign first_err_ch   = fe_ch_r;
  assign first_err_type = fe_type_r;
  assign first_err_time = fe_time_r;
`endif

endmodule
